// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial stimulus feeder: accepts words over valid/ready and shifts them
// out one bit per clock on x_o, with a one-word holding register for gap-free streaming.
module serial_bit_feeder #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              x_o,
   output logic              bit_valid_o,
   output logic              last_o,
   output logic              busy_o,
   output logic [15:0]       word_cnt_o
);

   localparam int unsigned CW = $clog2(DATA_W);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_W - 1);

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [15:0]       word_cnt_q, word_cnt_d;

   logic              accept;
   logic              cur_bit;
   logic [DATA_W-1:0] shreg_adv;

   assign accept  = valid_i & ~hold_full_q;
   assign cur_bit = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];

   always_comb begin
      if (MSB_FIRST) shreg_adv = {shreg_q[DATA_W-2:0], 1'b0};
      else           shreg_adv = {1'b0, shreg_q[DATA_W-1:1]};
   end

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;
      word_cnt_d  = word_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               shreg_d = data_i;
               cnt_d   = CNT_LOAD;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != '0) begin
               shreg_d = shreg_adv;
               cnt_d   = cnt_q - 1'b1;
               if (accept) begin
                  hold_d      = data_i;
                  hold_full_d = 1'b1;
               end
            end else begin
               // Last-bit edge: a held word has priority over a fresh accept.
               word_cnt_d = word_cnt_q + 16'd1;
               if (hold_full_q) begin
                  shreg_d     = hold_q;
                  hold_full_d = 1'b0;
                  cnt_d       = CNT_LOAD;
               end else if (accept) begin
                  shreg_d = data_i;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign ready_o     = ~hold_full_q;
   assign bit_valid_o = (state_q == ST_SHIFT);
   assign x_o         = bit_valid_o ? cur_bit : IDLE_BIT;
   assign last_o      = bit_valid_o & (cnt_q == '0);
   assign busy_o      = (state_q == ST_SHIFT) | hold_full_q;
   assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: a per-cycle vector table for a single word
// plus hand-written sequences for streaming, backpressure, reset, LSB-first and wrap.
module tb_serial_bit_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data, data2;
   logic        valid, valid2;
   logic        ready, x, bv, last, busy;
   logic        ready2, x2, bv2, last2, busy2;
   logic [15:0] wc, wc2;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   serial_bit_feeder dut (
      .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready),
      .x_o(x), .bit_valid_o(bv), .last_o(last), .busy_o(busy), .word_cnt_o(wc)
   );

   serial_bit_feeder #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
      .clk_i(clk), .rst_i(rst), .data_i(data2), .valid_i(valid2), .ready_o(ready2),
      .x_o(x2), .bit_valid_o(bv2), .last_o(last2), .busy_o(busy2), .word_cnt_o(wc2)
   );

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        x;
      logic        bv;
      logic        last;
      logic        rdy;
      logic        busy;
      logic [15:0] wc;
   } vec_t;

   vec_t tv[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      valid = 1'b0; valid2 = 1'b0; data = '0; data2 = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0]  hist;
      int unsigned det;
      logic [15:0] exp16;
      logic [23:0] got24;
      logic [7:0]  got8, bvs8;
      int          acc_edge[3];
      logic [7:0]  words[3];
      int unsigned idx, nbits;
      logic        acc;

      rst = 1'b1; valid = 1'b0; valid2 = 1'b0; data = '0; data2 = '0;
      #2;
      chk("reset_x", x, 1'b0);
      chk("reset_bv", bv, 1'b0);
      chk("reset_ready", ready, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_wc", wc, 16'h0000);
      do_reset();

      // Single word 8'hA5, MSB first
      tv[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
      tv[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
      tv[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
      tv[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
      tv[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
      tv[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
      tv[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
      tv[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0};
      tv[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
      tv[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
      hist = '0; det = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         valid = tv[i].v; data = tv[i].d;
         edge_sample();
         chk($sformatf("single_x[%0d]", i), x, tv[i].x);
         chk($sformatf("single_bv[%0d]", i), bv, tv[i].bv);
         chk($sformatf("single_last[%0d]", i), last, tv[i].last);
         chk($sformatf("single_ready[%0d]", i), ready, tv[i].rdy);
         chk($sformatf("single_busy[%0d]", i), busy, tv[i].busy);
         chk($sformatf("single_wc[%0d]", i), wc, tv[i].wc);
         if (bv) begin
            hist = {hist[1:0], x};
            if (hist == 3'b101) det++;
         end
      end
      chk("single_det101", det, 2);

      // Back-to-back A5, 5A with valid held high
      do_reset();
      exp16 = 16'hA55A;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         valid = (c < 2); data = (c == 0) ? 8'hA5 : 8'h5A;
         edge_sample();
         if (c < 16) begin
            chk($sformatf("b2b_bv[%0d]", c), bv, 1'b1);
            chk($sformatf("b2b_x[%0d]", c), x, exp16[15-c]);
         end else begin
            chk($sformatf("b2b_bv[%0d]", c), bv, 1'b0);
         end
         if (c >= 1 && c <= 7) chk($sformatf("b2b_ready_low[%0d]", c), ready, 1'b0);
         if (c == 8) chk("b2b_ready_back", ready, 1'b1);
      end
      chk("b2b_wc", wc, 16'd2);

      // Backpressure: three words queued with valid held
      do_reset();
      words[0] = 8'hC3; words[1] = 8'h96; words[2] = 8'h3C;
      acc_edge[0] = -1; acc_edge[1] = -1; acc_edge[2] = -1;
      idx = 0; nbits = 0; got24 = '0;
      for (int c = 0; c < 28; c++) begin
         @(negedge clk);
         valid = (idx < 3);
         data  = (idx < 3) ? words[idx] : 8'h00;
         acc   = valid & ready;
         edge_sample();
         if (acc) begin
            acc_edge[idx] = c;
            idx++;
         end
         if (bv && c < 24) begin
            got24 = {got24[22:0], x};
            nbits++;
         end
      end
      chk("bp_acc0", acc_edge[0], 0);
      chk("bp_acc1", acc_edge[1], 1);
      chk("bp_acc2", acc_edge[2], 9);
      chk("bp_nbits", nbits, 24);
      chk("bp_stream", got24, 24'hC3963C);
      chk("bp_wc", wc, 16'd3);

      // Asynchronous reset during bit 4 of 8'hFF with a word held
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         valid = (c < 2); data = (c == 0) ? 8'hFF : 8'h77;
         edge_sample();
      end
      chk("rst_pre_x", x, 1'b1);
      chk("rst_pre_ready", ready, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_x", x, 1'b0);
      chk("rst_async_bv", bv, 1'b0);
      chk("rst_async_ready", ready, 1'b1);
      chk("rst_async_wc", wc, 16'd0);
      chk("rst_async_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0; valid = 1'b0;
      got8 = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         valid = (c == 0); data = 8'h81;
         edge_sample();
         if (c < 8) got8 = {got8[6:0], x};
      end
      chk("rst_after_word", got8, 8'h81);
      chk("rst_after_idle_bv", bv, 1'b0);
      chk("rst_after_wc", wc, 16'd1);

      // LSB first, idle level 1
      do_reset();
      chk("lsb_idle_before", x2, 1'b1);
      got8 = '0; bvs8 = '0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         valid2 = (c == 0); data2 = 8'h01;
         edge_sample();
         if (c < 8) begin
            got8 = {got8[6:0], x2};
            bvs8 = {bvs8[6:0], bv2};
         end
      end
      chk("lsb_bits", got8, 8'b1000_0000);
      chk("lsb_bv", bvs8, 8'hFF);
      chk("lsb_idle_after_x", x2, 1'b1);
      chk("lsb_idle_after_bv", bv2, 1'b0);

      // Counter wrap from 16'hFFFE
      do_reset();
      @(negedge clk);
      force dut.word_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut.word_cnt_q;
      #1;
      chk("wrap_start", wc, 16'hFFFE);
      for (int w = 0; w < 2; w++) begin
         for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            valid = (c == 0); data = 8'h3C;
            edge_sample();
         end
         chk($sformatf("wrap_wc[%0d]", w), wc, (w == 0) ? 16'hFFFF : 16'h0000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
